// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver: collects WIDTH strobed bits (MSB- or LSB-first per frame) into a word.
// Latency: word appears on par_out/par_valid 1 cycle after the edge that samples its last bit.
// Backpressure: none on the serial side; a word completing while par_out is unconsumed is dropped and sets overrun.
module sipo_deserializer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             dir,
    input  logic             flush,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   par_out_q, par_out_d;
    logic               par_valid_q, par_valid_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic               dir_eff;
    logic [WIDTH-1:0]   sr_shift;
    logic               complete;
    logic               consume;
    logic               load;
    logic               drop;

    // Next-state logic: frame assembly, output handshake and sticky overrun.
    always_comb begin
        // Flush beats a simultaneous strobe, so the bit is simply not accepted.
        accept   = ser_valid & ~flush;
        // Direction is captured on the first bit; later changes are ignored.
        dir_eff  = (state_q == ST_IDLE) ? dir : dir_q;
        sr_shift = dir_eff ? {ser_in, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], ser_in};
        complete = accept & (cnt_q == LAST_CNT);
        consume  = par_valid_q & par_ready;
        // A completing word may take the slot freed by a same-cycle consume.
        load     = complete & (~par_valid_q | consume);
        drop     = complete & par_valid_q & ~par_ready;

        sr_d        = sr_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        par_out_d   = par_out_q;
        par_valid_d = par_valid_q;
        overrun_d   = overrun_q;

        if (flush) begin
            cnt_d = '0;
        end else if (accept) begin
            sr_d  = sr_shift;
            cnt_d = complete ? '0 : cnt_q + CNT_W'(1);
            if (state_q == ST_IDLE) begin
                dir_d = dir;
            end
        end

        if (load) begin
            par_out_d   = sr_shift;
            par_valid_d = 1'b1;
        end else if (consume) begin
            par_valid_d = 1'b0;
        end

        // A new drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end

        state_d = (cnt_d != '0) ? ST_SHIFT : ST_IDLE;
        busy_d  = (cnt_d != '0);
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            sr_q        <= '0;
            par_out_q   <= '0;
            par_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            sr_q        <= sr_d;
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign par_out   = par_out_q;
    assign par_valid = par_valid_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer with WIDTH=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Every check is inline inside its scenario task.
module tb_sipo_deserializer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             ser_in;
    logic             ser_valid;
    logic             dir;
    logic             flush;
    logic             ovr_clr;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             par_ready;
    logic             overrun;
    logic             busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sipo_deserializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .dir       (dir),
        .flush     (flush),
        .ovr_clr   (ovr_clr),
        .par_out   (par_out),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bit for exactly one edge; a following send keeps the strobe contiguous.
    task automatic send_bit(input logic b);
        ser_in    = b;
        ser_valid = 1'b1;
        tick();
        ser_valid = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w);
        logic [3:0] v;
        v = w;
        for (int i = 3; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic test_reset();
        reset = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; dir = 1'b0;
        flush = 1'b0; ovr_clr = 1'b0; par_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        total_cnt++; if (par_out !== 4'b0000) $display("FAIL reset_par_out got=%b exp=0000", par_out); else pass_cnt++;
        total_cnt++; if (par_valid !== 1'b0) $display("FAIL reset_par_valid got=%b exp=0", par_valid); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", overrun); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_msb_first();
        dir = 1'b0; par_ready = 1'b0;
        send_bit(1'b1);
        total_cnt++; if (busy !== 1'b1) $display("FAIL msb_busy_b1 got=%b exp=1", busy); else pass_cnt++;
        send_bit(1'b0);
        send_bit(1'b1);
        total_cnt++; if (busy !== 1'b1) $display("FAIL msb_busy_b3 got=%b exp=1", busy); else pass_cnt++;
        total_cnt++; if (par_valid !== 1'b0) $display("FAIL msb_early_valid got=%b exp=0", par_valid); else pass_cnt++;
        send_bit(1'b0);
        total_cnt++; if (par_valid !== 1'b1) $display("FAIL msb_valid got=%b exp=1", par_valid); else pass_cnt++;
        total_cnt++; if (par_out !== 4'b1010) $display("FAIL msb_word got=%b exp=1010", par_out); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL msb_busy_done got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL msb_overrun got=%b exp=0", overrun); else pass_cnt++;
        tick();
        total_cnt++; if (par_valid !== 1'b1) $display("FAIL msb_hold_valid got=%b exp=1", par_valid); else pass_cnt++;
        par_ready = 1'b1;
        tick();
        par_ready = 1'b0;
        total_cnt++; if (par_valid !== 1'b0) $display("FAIL msb_drain_valid got=%b exp=0", par_valid); else pass_cnt++;
        total_cnt++; if (par_out !== 4'b1010) $display("FAIL msb_drain_hold got=%b exp=1010", par_out); else pass_cnt++;
    endtask

    task automatic test_lsb_gaps();
        dir = 1'b1;
        send_bit(1'b1); tick(); tick();
        send_bit(1'b0);
        dir = 1'b0;
        tick(); tick();
        total_cnt++; if (busy !== 1'b1) $display("FAIL lsb_gap_busy got=%b exp=1", busy); else pass_cnt++;
        send_bit(1'b1); tick(); tick();
        send_bit(1'b1);
        total_cnt++; if (par_valid !== 1'b1) $display("FAIL lsb_valid got=%b exp=1", par_valid); else pass_cnt++;
        total_cnt++; if (par_out !== 4'b1101) $display("FAIL lsb_word got=%b exp=1101", par_out); else pass_cnt++;
        par_ready = 1'b1; tick(); par_ready = 1'b0;
    endtask

    task automatic test_overrun();
        dir = 1'b0; par_ready = 1'b0;
        send_word(4'b1010);
        send_word(4'b0110);
        total_cnt++; if (par_out !== 4'b1010) $display("FAIL ovr_keep_word got=%b exp=1010", par_out); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set got=%b exp=1", overrun); else pass_cnt++;
        total_cnt++; if (par_valid !== 1'b1) $display("FAIL ovr_valid got=%b exp=1", par_valid); else pass_cnt++;
        tick();
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got=%b exp=1", overrun); else pass_cnt++;
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clear got=%b exp=0", overrun); else pass_cnt++;
        // Completion in the same cycle as a consume: new word replaces old one.
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        par_ready = 1'b1;
        send_bit(1'b1);
        par_ready = 1'b0;
        total_cnt++; if (par_out !== 4'b0011) $display("FAIL ovr_swap_word got=%b exp=0011", par_out); else pass_cnt++;
        total_cnt++; if (par_valid !== 1'b1) $display("FAIL ovr_swap_valid got=%b exp=1", par_valid); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_swap_overrun got=%b exp=0", overrun); else pass_cnt++;
        // Clear and a fresh drop in the same cycle: the drop wins.
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        ovr_clr = 1'b1;
        send_bit(1'b1);
        ovr_clr = 1'b0;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_clr_race got=%b exp=1", overrun); else pass_cnt++;
        total_cnt++; if (par_out !== 4'b0011) $display("FAIL ovr_race_word got=%b exp=0011", par_out); else pass_cnt++;
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        par_ready = 1'b1; tick(); par_ready = 1'b0;
        total_cnt++; if (par_valid !== 1'b0) $display("FAIL ovr_drain got=%b exp=0", par_valid); else pass_cnt++;
    endtask

    task automatic test_flush();
        dir = 1'b0;
        send_bit(1'b1); send_bit(1'b1);
        flush = 1'b1;
        send_bit(1'b1);
        flush = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL flush_busy got=%b exp=0", busy); else pass_cnt++;
        send_word(4'b0110);
        total_cnt++; if (par_out !== 4'b0110) $display("FAIL flush_word got=%b exp=0110", par_out); else pass_cnt++;
        total_cnt++; if (par_valid !== 1'b1) $display("FAIL flush_valid got=%b exp=1", par_valid); else pass_cnt++;
        flush = 1'b1; tick(); flush = 1'b0;
        total_cnt++; if (par_valid !== 1'b1) $display("FAIL flush_idle_valid got=%b exp=1", par_valid); else pass_cnt++;
        total_cnt++; if (par_out !== 4'b0110) $display("FAIL flush_idle_word got=%b exp=0110", par_out); else pass_cnt++;
        par_ready = 1'b1; tick(); par_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        dir = 1'b0; par_ready = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        total_cnt++; if (par_out !== 4'b1001) $display("FAIL b2b_word1 got=%b exp=1001", par_out); else pass_cnt++;
        total_cnt++; if (par_valid !== 1'b1) $display("FAIL b2b_valid1 got=%b exp=1", par_valid); else pass_cnt++;
        send_bit(1'b0);
        total_cnt++; if (par_valid !== 1'b0) $display("FAIL b2b_pulse1 got=%b exp=0", par_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy got=%b exp=1", busy); else pass_cnt++;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        total_cnt++; if (par_out !== 4'b0111) $display("FAIL b2b_word2 got=%b exp=0111", par_out); else pass_cnt++;
        total_cnt++; if (par_valid !== 1'b1) $display("FAIL b2b_valid2 got=%b exp=1", par_valid); else pass_cnt++;
        tick();
        total_cnt++; if (par_valid !== 1'b0) $display("FAIL b2b_pulse2 got=%b exp=0", par_valid); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_overrun got=%b exp=0", overrun); else pass_cnt++;
        par_ready = 1'b0;
    endtask

    task automatic test_reset_midframe();
        dir = 1'b0; par_ready = 1'b0;
        send_word(4'b1010);
        send_word(4'b0110);
        send_bit(1'b1); send_bit(1'b1);
        total_cnt++; if ({par_valid, overrun, busy} !== 3'b111) $display("FAIL rstm_pre got=%b exp=111", {par_valid, overrun, busy}); else pass_cnt++;
        reset = 1'b1; tick(); reset = 1'b0;
        total_cnt++; if (par_out !== 4'b0000) $display("FAIL rstm_par_out got=%b exp=0000", par_out); else pass_cnt++;
        total_cnt++; if ({par_valid, overrun, busy} !== 3'b000) $display("FAIL rstm_flags got=%b exp=000", {par_valid, overrun, busy}); else pass_cnt++;
        send_word(4'b0011);
        total_cnt++; if (par_out !== 4'b0011) $display("FAIL rstm_word got=%b exp=0011", par_out); else pass_cnt++;
        total_cnt++; if (par_valid !== 1'b1) $display("FAIL rstm_valid got=%b exp=1", par_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_gaps();
        test_overrun();
        test_flush();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-to-parallel receiver: the receiving end of the serial link driven by the universal shift register's shift modes. Collects WIDTH bits from a 1-bit strobed stream, MSB-first or LSB-first selected per frame. Presents each completed word on a registered valid/ready output port. Flags overrun when a word completes while the previous one is still unconsumed.

Parameters:
WIDTH, 4, word width in bits (>= 2)
CNT_W, $clog2(WIDTH+1), width of the bit counter

Ports:
clk  input  1  rising-edge clock, single clock domain
reset  input  1  synchronous, active-high reset
ser_in  input  1  serial data bit, sampled only when ser_valid=1
ser_valid  input  1  bit strobe; one bit accepted per cycle with ser_valid=1; no backpressure
dir  input  1  0 = MSB-first (shift left, new bit into bit 0); 1 = LSB-first (shift right, new bit into bit WIDTH-1); sampled on the first bit of a frame only
flush  input  1  abort the partial frame in progress
ovr_clr  input  1  clear the sticky overrun flag
par_out  output  WIDTH  received word; stable while par_valid=1
par_valid  output  1  par_out holds an unconsumed word
par_ready  input  1  consumer accepts par_out when par_valid & par_ready
overrun  output  1  sticky: a completed word was dropped
busy  output  1  partial frame in progress (bit count != 0)

Behaviour:
- Clock/reset: one clock domain; reset is synchronous and active-high, and all state updates on the rising edge of clk.
- Reset: shift register=0, bit count=0, latched dir=0, par_out=0, par_valid=0, overrun=0, busy=0. Reset mid-frame discards the partial frame. Reset takes priority over all other inputs.
- Frame FSM: IDLE (count=0) and SHIFT (1 <= count <= WIDTH-1).
- IDLE + ser_valid: latch dir, shift in ser_in, count=1, go to SHIFT.
- SHIFT + ser_valid: shift in ser_in in the latched direction, count+1. A dir change mid-frame is ignored.
- MSB-first: sr <= {sr[WIDTH-2:0], ser_in}. LSB-first: sr <= {ser_in, sr[WIDTH-1:1]}.
- Completion: the WIDTH-th accepted bit forms the word (sr after the shift), returns count to 0 and goes to IDLE. A new frame may start on the very next cycle; back-to-back frames run with no gap.
- Output load: on completion, if par_valid=0 or (par_valid & par_ready) in the same cycle, then par_out <= new word and par_valid=1 on the next cycle. Latency is 1 cycle from the edge that samples the last bit.
- Overrun: on completion with par_valid=1 & par_ready=0, the new word is dropped, par_out keeps the old word and overrun <= 1.
- Overrun clearing: overrun clears only on reset or ovr_clr. If ovr_clr and a new overrun event occur in the same cycle, the event wins (overrun stays 1).
- Drain: par_valid & par_ready with no completion in that cycle gives par_valid=0 next cycle; par_out holds its last value.
- Flush: count=0, go to IDLE, partial bits discarded. flush with ser_valid in the same cycle: flush wins and the bit is discarded. Flush does not affect par_out, par_valid or overrun. Flush in IDLE is a no-op.
- Gaps: cycles with ser_valid=0 hold all frame state; there is no timeout.
- busy = (count != 0), registered.

Test Plan:
1. WIDTH=4, dir=0, bits 1,0,1,0 on consecutive cycles, par_ready=0 -> par_out=4'b1010, par_valid=1 exactly 1 cycle after the 4th bit; busy=1 during bits 2-4; overrun=0.
2. dir=1, bits 1,0,1,1 with ser_valid gaps of 2 cycles between bits -> par_out=4'b1101. Toggling dir to 0 after bit 2 has no effect on the result.
3. Backpressure: frame 1010 left unconsumed (par_ready=0), then frame 0110 completes -> par_out stays 4'b1010, overrun=1. Pulse ovr_clr -> overrun=0. Separately, completion of a word in the same cycle as par_ready=1 -> new word loaded, overrun=0.
4. Flush: dir=0, bits 1,1, then flush with ser_valid=1 and ser_in=1 in the same cycle, then bits 0,1,1,0 -> par_out=4'b0110, busy=0 after the flush cycle.
5. Back-to-back: 8 consecutive bits 1,0,0,1,0,1,1,1 (dir=0) with par_ready=1 -> words 4'b1001 then 4'b0111, each with par_valid high for 1 cycle, no overrun.
6. Reset mid-frame after 2 bits with par_valid=1 and overrun=1 -> the cycle after reset, all outputs=0. Next frame 0,0,1,1 (dir=0) -> par_out=4'b0011.
